product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Downstream consumer of the booth_multiplier product: accepts a stream of signed 2N-bit products over a valid/ready handshake.
- Sums a programmed number of products into a wider signed accumulator, with saturation, and presents the total on an output valid/ready handshake.
- Sits between the combinational multiplier and whatever consumes dot-product or MAC results.

Parameters:
- N, 10, operand width of the upstream multiplier; product width is 2N.
- ACC_W, 24, accumulator width; must be >= 2N, otherwise elaboration error.
- LEN_W, 8, width of the term-count input.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
- len  input  LEN_W  number of products to sum; sampled when start is honoured.
- p_valid  input  1  upstream product valid.
- p_ready  output  1  block accepts a product this cycle.
- p_data  input  2N  signed product from booth_multiplier.
- acc_valid  output  1  result available.
- acc_ready  input  1  downstream accepts the result.
- acc_data  output  ACC_W  signed accumulated result.
- sat_flag  output  1  sticky; set if any addition in the current run saturated.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; acc_data=0, sat_flag=0, count=0; p_ready=0, acc_valid=0, busy=0. Reset applies in any state and discards a run in progress.
- States: IDLE, ACCUM, HOLD.
- IDLE, start=1, len!=0: clear acc, clear sat_flag, load count=len, go to ACCUM.
- IDLE, start=1, len==0: acc=0, sat_flag=0, go directly to HOLD.
- IDLE, start=0: stay in IDLE.
- ACCUM: p_ready=1 (combinational, from state). A transfer occurs when p_valid & p_ready.
  - On each transfer: acc <= sat(acc + sign-extended p_data); count decrements.
  - On the transfer with count==1: go to HOLD.
  - No transfer: hold all state.
- HOLD: acc_valid=1 and acc_data stable. On acc_ready=1 go to IDLE; acc_data and sat_flag keep their values until the next honoured start.
- start in ACCUM or HOLD: ignored, no side effects.
- Latency: acc_valid rises on the cycle after the last product transfer. A back-to-back stream of L products completes in L cycles plus 1.
- Arithmetic: compute the sum at ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value.
  - If the sum is below -2^(ACC_W-1), clamp to that value.
  - Either clamp sets sat_flag, which stays set for the rest of the run.
  - Once clamped, later terms continue to be added to the clamped value.
- p_ready is 0 in IDLE and HOLD, so no product is consumed outside ACCUM.
- acc_valid and acc_ready in the same cycle as entry to HOLD: acc_valid is registered, so the handshake completes no earlier than the first HOLD cycle.

Decomposition:
- Shared package booth_pkg:
  - state enum acc_state_t {IDLE, ACCUM, HOLD}.
  - default width constants for N, ACC_W and LEN_W.
  - a saturating-add function parameterised by width.
- Optional sub-module sat_adder (ACC_W-bit signed add with clamp and overflow output). Keep the FSM and counters in product_accumulator.

Test Plan:
- Three-term run, N=10, ACC_W=24: start with len=3; feed -56, 21800, 40000 back-to-back (-4*14, 218*100, -100*-400) -> acc_valid one cycle after the third transfer, acc_data=61744, sat_flag=0.
- Backpressure and bubbles: same three products with p_valid gaps of 0, 2 and 1 cycles, and acc_ready held low for 3 cycles -> same result; acc_data stable throughout HOLD; p_ready=0 in HOLD.
- Saturation, ACC_W=20: len=14, each product 40000 -> acc_data=524287, sat_flag=1. Next run len=1 with product -56 -> acc_data=-56, sat_flag=0.
- Negative saturation, ACC_W=20: len=3, each product -261121 (-511*511) -> acc_data=-524288, sat_flag=1.
- len=0: start with len=0 -> HOLD on the next cycle, acc_data=0, no products consumed.
- Start is ignored while busy: assert start with len=5 during an ACCUM run of len=2 -> exactly 2 products consumed.
- Reset mid-run: rst_n low for one cycle after 1 of 3 products -> IDLE, acc_data=0, p_ready=0, acc_valid=0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth multiplier / product accumulator.
// Holds the accumulator state encoding and a width-generic saturating add.
package booth_pkg;

  localparam int N_DEF     = 10;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  typedef logic signed [SAT_MAX_W-1:0] sat_word_t;

  // a and b must already be sign-extended values of a w-bit range
  function automatic sat_word_t sat_add(
    input  sat_word_t   a,
    input  sat_word_t   b,
    input  int unsigned w,
    output logic        ovf
  );
    logic signed [SAT_MAX_W:0] s;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_word_t                 r;
    s  = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    ovf = 1'b1;
    if (s > hi) begin
      r = hi[SAT_MAX_W-1:0];
    end else if (s < lo) begin
      r = lo[SAT_MAX_W-1:0];
    end else begin
      ovf = 1'b0;
      r   = s[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// W-bit signed adder that clamps to the representable range.
// ovf reports that the result was clamped.
module sat_adder
  import booth_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  sat_word_t r;

  always_comb begin
    r   = sat_add(sat_word_t'(a), sat_word_t'(b), W, ovf);
    sum = W'(r);
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed products with saturation and
// hands the total downstream over a valid/ready handshake.
module product_accumulator
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [2*N-1:0]   p_data,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             sat_flag,
  output logic             busy
);

  if (ACC_W < 2 * N) begin : g_bad_width
    $error("product_accumulator: ACC_W must be >= 2*N");
  end

  acc_state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;

  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;

  assign term = ACC_W'($signed(p_data));

  sat_adder #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (term),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = len;
          state_d = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (p_valid) begin
          acc_d = sum;
          sat_d = sat_q | ovf;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_ready   = (state_q == ACCUM);
    acc_valid = (state_q == HOLD);
    busy      = (state_q == ACCUM) || (state_q == HOLD);
    acc_data  = acc_q;
    sat_flag  = sat_q;
  end

endmodule
